dro_pulse_sequencer: RTL and testbench

//  Upstream driver for the basic DRO cell: accepts SET/READ/NOP commands from a testbench or controller,

---
 rtl/dro_seq_pkg.sv | 23 ++
 rtl/dro_seq_fifo.sv | 57 +++++
 rtl/dro_pulse_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_dro_pulse_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dro_seq_pkg.sv
// rtl/dro_seq_pkg.sv - op encodings, FSM state type and timing defaults for the DRO pulse sequencer
package dro_seq_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;

  localparam int unsigned DEF_MIN_SEP = 3;
  localparam int unsigned DEF_OUT_LAT = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_GAP
  } seq_state_e;

  // Only SET and READ drive an edge; NOP and the reserved code are silent.
  function automatic logic is_edge_op(input logic [1:0] op);
    return (op == OP_SET) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/dro_seq_fifo.sv
// rtl/dro_seq_fifo.sv - synchronous command FIFO with occupancy, full and empty flags
module dro_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dro_pulse_sequencer.sv
// rtl/dro_pulse_sequencer.sv - toggle-edge SET/READ driver for a DRO cell with shadow model
// Optional readback checker enabled by defining DRO_SEQ_CHECK_EN.
module dro_pulse_sequencer
  import dro_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP_W   = 8,
  parameter int unsigned MIN_SEP = DEF_MIN_SEP,
  parameter int unsigned OUT_LAT = DEF_OUT_LAT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [GAP_W-1:0]         cmd_gap_i,
  output logic                     set_o,
  output logic                     reset_o,
  input  logic                     dro_out_i,
  output logic                     expected_out_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     err_mismatch_o,
  output logic [7:0]               err_count_o
);

  localparam int unsigned HOLD_W = $clog2(MIN_SEP + 1);
  localparam int unsigned FW     = 2 + GAP_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             pop;
  logic [FW-1:0]    fifo_rdata;
  logic [1:0]       head_op;
  logic [GAP_W-1:0] head_gap;

  seq_state_e       state_q;
  logic [1:0]       cur_op_q;
  logic [GAP_W-1:0] cur_gap_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             set_q;
  logic             reset_q;
  logic             model_state_q;
  logic             exp_out_q;
  logic             hold_done;

  assign fifo_push   = cmd_valid_i && cmd_ready_o;
  assign cmd_ready_o = !fifo_full;
  assign head_op     = fifo_rdata[FW-1:GAP_W];
  assign head_gap    = fifo_rdata[GAP_W-1:0];

  dro_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (pop),
    .wdata_i ({cmd_op_i, cmd_gap_i}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A zero gap lets the last hold cycle pop directly, keeping edges exactly MIN_SEP+1 apart.
  always_comb begin
    hold_done = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_ISSUE: hold_done = !is_edge_op(cur_op_q);
      ST_HOLD:  hold_done = (hold_cnt_q <= HOLD_W'(1));
      default:  hold_done = 1'b0;
    endcase
    case (state_q)
      ST_IDLE: pop = !fifo_empty;
      ST_GAP:  pop = (gap_cnt_q <= GAP_W'(1)) && !fifo_empty;
      default: pop = hold_done && (cur_gap_q == '0) && !fifo_empty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cur_op_q      <= OP_NOP;
      cur_gap_q     <= '0;
      hold_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      set_q         <= 1'b0;
      reset_q       <= 1'b0;
      model_state_q <= 1'b0;
      exp_out_q     <= 1'b0;
    end else begin
      if (pop) begin
        cur_op_q  <= head_op;
        cur_gap_q <= head_gap;
      end
      case (state_q)
        ST_IDLE: begin
          if (pop) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (cur_op_q == OP_SET) begin
            set_q         <= ~set_q;
            model_state_q <= 1'b1;
          end else if (cur_op_q == OP_READ) begin
            reset_q <= ~reset_q;
            if (model_state_q) begin
              exp_out_q     <= ~exp_out_q;
              model_state_q <= 1'b0;
            end
          end
          if (!hold_done) begin
            hold_cnt_q <= HOLD_W'(MIN_SEP);
            state_q    <= ST_HOLD;
          end else if (cur_gap_q != '0) begin
            gap_cnt_q <= cur_gap_q;
            state_q   <= ST_GAP;
          end else begin
            state_q <= pop ? ST_ISSUE : ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!hold_done) begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end else if (cur_gap_q != '0) begin
            gap_cnt_q <= cur_gap_q;
            state_q   <= ST_GAP;
          end else begin
            state_q <= pop ? ST_ISSUE : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q > GAP_W'(1)) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end else begin
            state_q <= pop ? ST_ISSUE : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign set_o          = set_q;
  assign reset_o        = reset_q;
  assign expected_out_o = exp_out_q;
  assign busy_o         = !fifo_empty || (state_q != ST_IDLE);

`ifdef DRO_SEQ_CHECK_EN
  logic [OUT_LAT-1:0] pend_q;
  logic               err_q;
  logic [7:0]         err_cnt_q;
  logic               read_issue;

  assign read_issue = (state_q == ST_ISSUE) && (cur_op_q == OP_READ);

  // Each READ edge walks down the shift register; overlapping READs each get their own sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pend_q <= (pend_q << 1) | OUT_LAT'(read_issue);
      err_q  <= 1'b0;
      if (pend_q[OUT_LAT-1] && (dro_out_i != exp_out_q)) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign err_mismatch_o = err_q;
  assign err_count_o    = err_cnt_q;
`else
  localparam int unsigned unused_out_lat = OUT_LAT;
  logic unused_dro_out;

  assign unused_dro_out = dro_out_i;
  assign err_mismatch_o = 1'b0;
  assign err_count_o    = '0;
`endif

endmodule

// File: tb/tb_dro_pulse_sequencer.sv
// tb/tb_dro_pulse_sequencer.sv - scoreboard bench for dro_pulse_sequencer (DRO_SEQ_CHECK_EN aware)
module tb_dro_pulse_sequencer;
  import dro_seq_pkg::*;

  localparam int DEPTH   = 4;
  localparam int GAP_W   = 8;
  localparam int MIN_SEP = 3;
  localparam int OUT_LAT = 6;

  typedef struct {
    logic [1:0] op;
    int         cyc;
    logic       out;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [1:0]             cmd_op_i;
  logic [GAP_W-1:0]       cmd_gap_i;
  logic                   set_o;
  logic                   reset_o;
  logic                   dro_out_i;
  logic                   expected_out_o;
  logic                   busy_o;
  logic [$clog2(DEPTH):0] fifo_count_o;
  logic                   err_mismatch_o;
  logic [7:0]             err_count_o;

  dro_pulse_sequencer #(
    .DEPTH   (DEPTH),
    .GAP_W   (GAP_W),
    .MIN_SEP (MIN_SEP),
    .OUT_LAT (OUT_LAT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_op_i       (cmd_op_i),
    .cmd_gap_i      (cmd_gap_i),
    .set_o          (set_o),
    .reset_o        (reset_o),
    .dro_out_i      (dro_out_i),
    .expected_out_o (expected_out_o),
    .busy_o         (busy_o),
    .fifo_count_o   (fifo_count_o),
    .err_mismatch_o (err_mismatch_o),
    .err_count_o    (err_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DRO: set edge stores 1, reset edge emits an output toggle if a 1 was stored.
  logic dro_q, dro_st, sp_q, rp_q, stub;
  always @(posedge clk) begin
    if (rst_i) begin
      dro_st <= 1'b0; dro_q <= 1'b0; sp_q <= 1'b0; rp_q <= 1'b0;
    end else begin
      if (set_o !== sp_q) dro_st <= 1'b1;
      if (reset_o !== rp_q) begin
        if (dro_st) dro_q <= ~dro_q;
        dro_st <= 1'b0;
      end
      sp_q <= set_o;
      rp_q <= reset_o;
    end
  end
  assign dro_out_i = stub ? 1'b0 : dro_q;

  exp_t sb_q[$];
  int   set_edges[$];
  int   n_checks = 0, n_fail = 0;
  int   last_free, edge_cnt = 0, last_reset_cyc = 0;
  int   err_pulses, err_cyc, peak, ready_bad;
  logic m_state, m_out;
  bit   mon_en = 1'b0;
  logic set_prev_m = 1'b0, reset_prev_m = 1'b0;

  always @(negedge clk) begin
    logic [1:0] got;
    exp_t e;
    if (mon_en) begin
      if (set_o !== set_prev_m || reset_o !== reset_prev_m) begin
        got = {reset_o !== reset_prev_m, set_o !== set_prev_m};
        edge_cnt++;
        if (got == OP_SET) set_edges.push_back(cyc);
        if (got == OP_READ) last_reset_cyc = cyc;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_edge op=%0d cyc=%0d required no edge", got, cyc);
        end else begin
          e = sb_q.pop_front();
          if (got !== e.op || cyc != e.cyc || expected_out_o !== e.out) begin
            n_fail++;
            $display("FAIL edge op=%0d cyc=%0d out=%b required op=%0d cyc=%0d out=%b",
                     got, cyc, expected_out_o, e.op, e.cyc, e.out);
          end
        end
      end
      if (err_mismatch_o === 1'b1) begin
        err_pulses++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (int'(fifo_count_o) > peak) peak = int'(fifo_count_o);
      if (fifo_count_o == 4 && cmd_ready_o) ready_bad++;
    end
    set_prev_m   = set_o;
    reset_prev_m = reset_o;
  end

  task automatic model_push(input logic [1:0] op, input int gap, input int a);
    int   issue;
    exp_t e;
    issue = (a + 2 > last_free) ? a + 2 : last_free;
    last_free = issue + (((op == OP_SET) || (op == OP_READ)) ? MIN_SEP : 0) + gap + 1;
    if (op == OP_SET) begin
      m_state = 1'b1;
      e.op = OP_SET; e.cyc = issue + 1; e.out = m_out;
      sb_q.push_back(e);
    end else if (op == OP_READ) begin
      if (m_state) begin
        m_out   = ~m_out;
        m_state = 1'b0;
      end
      e.op = OP_READ; e.cyc = issue + 1; e.out = m_out;
      sb_q.push_back(e);
    end
  endtask

  task automatic send(input logic [1:0] op, input int gap);
    int waited = 0;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_gap_i   = GAP_W'(gap);
    while (cmd_ready_o !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited >= 300) begin
      n_fail++;
      $display("FAIL send_timeout ready=%b required=1", cmd_ready_o);
    end else begin
      model_push(op, gap, cyc);
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((busy_o || sb_q.size() != 0) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (busy_o || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain busy=%b pending=%0d required busy=0 pending=0", busy_o, sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_model();
    sb_q.delete();
    set_edges.delete();
    last_free = 0; m_state = 1'b0; m_out = 1'b0;
    err_pulses = 0; err_cyc = -1; peak = 0; ready_bad = 0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    cmd_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    clear_model();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    cmd_valid_i = 1'b0; cmd_op_i = OP_NOP; cmd_gap_i = '0; stub = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    n_checks++;
    if ({set_o, reset_o, expected_out_o, busy_o, cmd_ready_o} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_outputs set/reset/exp/busy/ready=%b required 00001",
               {set_o, reset_o, expected_out_o, busy_o, cmd_ready_o});
    end
    n_checks++;
    if (fifo_count_o !== '0 || err_mismatch_o !== 1'b0 || err_count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counts count=%0d err=%b errcnt=%0d required 0 0 0",
               fifo_count_o, err_mismatch_o, err_count_o);
    end
    @(negedge clk);
    clear_model();
    mon_en = 1'b1;
  endtask

  task automatic test_set_read();
    int a;
    do_reset();
    a = cyc;
    send(OP_SET, 0);
    send(OP_READ, 0);
    wait_idle();
    repeat (OUT_LAT + 2) @(negedge clk);
    n_checks++;
    if (set_edges.size() != 1 || set_edges[0] - a != 3) begin
      n_fail++;
      $display("FAIL set_latency edges=%0d delta=%0d required 1 3", set_edges.size(), set_edges[0] - a);
    end
    n_checks++;
    if (last_reset_cyc - set_edges[0] != MIN_SEP + 1) begin
      n_fail++;
      $display("FAIL read_spacing delta=%0d required %0d", last_reset_cyc - set_edges[0], MIN_SEP + 1);
    end
    n_checks++;
    if (expected_out_o !== 1'b1 || err_count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL set_read_final exp=%b errcnt=%0d required 1 0", expected_out_o, err_count_o);
    end
  endtask

  task automatic test_read_no_set();
    do_reset();
    send(OP_READ, 0);
    send(OP_READ, 0);
    wait_idle();
    n_checks++;
    if (expected_out_o !== 1'b0 || reset_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_no_set exp=%b reset=%b required 0 0", expected_out_o, reset_o);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    send(OP_SET, 40);
    send(OP_READ, 0);
    send(OP_SET, 0);
    send(OP_READ, 0);
    send(OP_SET, 1);
    n_checks++;
    if (fifo_count_o !== 3'd4 || cmd_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full count=%0d ready=%b required 4 0", fifo_count_o, cmd_ready_o);
    end
    send(OP_READ, 0);
    wait_idle();
    n_checks++;
    if (peak != DEPTH || ready_bad != 0) begin
      n_fail++;
      $display("FAIL fifo_peak peak=%0d ready_when_full=%0d required %0d 0", peak, ready_bad, DEPTH);
    end
  endtask

  task automatic test_gap();
    do_reset();
    send(OP_SET, 10);
    send(OP_SET, 0);
    wait_idle();
    n_checks++;
    if (set_edges.size() != 2 || set_edges[1] - set_edges[0] != MIN_SEP + 1 + 10) begin
      n_fail++;
      $display("FAIL gap_spacing edges=%0d delta=%0d required 2 %0d",
               set_edges.size(), set_edges[1] - set_edges[0], MIN_SEP + 11);
    end
    n_checks++;
    if (expected_out_o !== 1'b0) begin
      n_fail++;
      $display("FAIL double_set exp=%b required 0", expected_out_o);
    end
  endtask

  task automatic test_nop_reserved();
    int e0;
    do_reset();
    e0 = edge_cnt;
    send(OP_NOP, 2);
    send(2'b11, 0);
    send(OP_SET, 0);
    wait_idle();
    n_checks++;
    if (edge_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL nop_edges edges=%0d required 1", edge_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    wait_idle();
    repeat (OUT_LAT + 2) @(negedge clk);
    n_checks++;
    if (err_count_o !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_errcnt errcnt=%0d required 0", err_count_o);
    end
  endtask

  task automatic test_checker();
    do_reset();
    stub = 1'b1;
    send(OP_SET, 0);
    send(OP_READ, 0);
    wait_idle();
    repeat (OUT_LAT + 4) @(negedge clk);
`ifdef DRO_SEQ_CHECK_EN
    n_checks++;
    if (err_count_o !== 8'd1 || err_pulses != 1) begin
      n_fail++;
      $display("FAIL checker_count errcnt=%0d pulses=%0d required 1 1", err_count_o, err_pulses);
    end
    n_checks++;
    if (err_cyc - last_reset_cyc != OUT_LAT) begin
      n_fail++;
      $display("FAIL checker_latency delta=%0d required %0d", err_cyc - last_reset_cyc, OUT_LAT);
    end
`else
    n_checks++;
    if (err_count_o !== 8'd0 || err_pulses != 0) begin
      n_fail++;
      $display("FAIL checker_off errcnt=%0d pulses=%0d required 0 0", err_count_o, err_pulses);
    end
`endif
    stub = 1'b0;
  endtask

  task automatic test_reset_mid();
    int e0;
    do_reset();
    send(OP_SET, 20);
    send(OP_READ, 0);
    send(OP_SET, 0);
    send(OP_READ, 0);
    repeat (8) @(negedge clk);
    n_checks++;
    if (fifo_count_o !== 3'd3 || set_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset count=%0d set=%b required 3 1", fifo_count_o, set_o);
    end
    mon_en = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_checks++;
    if (fifo_count_o !== '0 || {set_o, reset_o, busy_o, expected_out_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset count=%0d set/reset/busy/exp=%b required 0 0000",
               fifo_count_o, {set_o, reset_o, busy_o, expected_out_o});
    end
    @(negedge clk);
    clear_model();
    mon_en = 1'b1;
    e0 = edge_cnt;
    repeat (40) @(negedge clk);
    n_checks++;
    if (edge_cnt != e0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet edges=%0d busy=%b required 0 0", edge_cnt - e0, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_set_read();
    test_read_no_set();
    test_fifo_full();
    test_gap();
    test_nop_reserved();
    test_back_to_back();
    test_checker();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
